// File: rtl/wide_add_seq_pkg.sv
// Shared constants, state encoding and sizing helpers for the wide add/sub sequencer.
package wide_add_seq_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Slice index width; never below one bit so the index register always exists.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/wide_add_seq_adder_16.sv
// 16-bit carry-lookahead adder slice: four 4-bit groups with group generate/propagate.
module adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_c,
    output logic        out_c,
    output logic [15:0] s
);

    logic [15:0] p;
    logic [15:0] g;
    logic [16:0] c;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [4:0]  grp_c;

    always_comb begin
        p     = a ^ b;
        g     = a & b;
        grp_p = '0;
        grp_g = '0;
        grp_c = '0;
        c     = '0;

        // Group generate/propagate over each nibble.
        for (int k = 0; k < 4; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end

        grp_c[0] = in_c;
        for (int k = 0; k < 4; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end

        for (int k = 0; k < 4; k++) begin
            c[4*k] = grp_c[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[16] = grp_c[4];

        s     = p ^ c[15:0];
        out_c = c[16];
    end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle WORDS*16-bit add/subtract sequencer time-sharing one adder_16 slice,
// least significant slice first, with valid/ready handshakes on both sides.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    input  logic                       sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   sum,
    output logic                       carry,
    output logic                       overflow,
    output logic                       zero
);

    localparam int unsigned W     = SLICE_W * WORDS;
    localparam int unsigned IDX_W = idx_width(WORDS);

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               cin_q;
    logic [W-1:0]       opa_q;
    logic [W-1:0]       opb_q;

    logic [SLICE_W-1:0] slice_a_c;
    logic [SLICE_W-1:0] slice_b_c;
    logic [SLICE_W-1:0] slice_s_c;
    logic               slice_cout_c;
    logic               last_c;
    logic [W-1:0]       sum_nx_c;

    adder_16 u_adder (
        .a     (slice_a_c),
        .b     (slice_b_c),
        .in_c  (cin_q),
        .out_c (slice_cout_c),
        .s     (slice_s_c)
    );

    // Operand slice selection and the result as it will look after this edge.
    always_comb begin
        slice_a_c = opa_q[SLICE_W*idx_q +: SLICE_W];
        slice_b_c = opb_q[SLICE_W*idx_q +: SLICE_W];
        last_c    = (idx_q == IDX_W'(WORDS - 1));
        sum_nx_c  = sum;
        sum_nx_c[SLICE_W*idx_q +: SLICE_W] = slice_s_c;
    end

    // Next-state logic; the unused 2'b11 code behaves as IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: if (in_valid)  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // Datapath: operand latch, slice walk with carry chaining, flag capture on the last slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            cin_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    sum   <= sum_nx_c;
                    cin_q <= slice_cout_c;
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_c) begin
                        carry    <= slice_cout_c;
                        overflow <= (opa_q[W-1] ^ opb_q[W-1] ^ slice_s_c[SLICE_W-1]) ^ slice_cout_c;
                        zero     <= ~|sum_nx_c;
                    end
                end
                DONE: begin
                end
                default: begin
                    if (in_valid) begin
                        opa_q <= a;
                        opb_q <= sub ? ~b : b;
                        cin_q <= sub;
                        idx_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule
